// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/accept producers.
// Optional stall counter (stall_cnt/stall_clr) enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    input  logic                        stall_clr,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [OW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;
    logic [OW-1:0] next_ptr;
    logic          xfer;
    logic          exit_grant;

    // First requester at or after p, wrapping; scanned downward so the nearest one wins.
    function automatic logic [OW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [OW-1:0] p);
        logic [OW-1:0] w;
        int            idx;
        w = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NUM_REQ;
            if (r[idx]) w = OW'(idx);
        end
        return w;
    endfunction

    assign xfer       = (state == GRANT) && req[owner] && !fifo_full && !reset;
    assign exit_grant = (xfer && (burst_cnt == BW'(MAX_BURST - 1))) || !req[owner];
    assign next_ptr   = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
    assign busy       = (state == GRANT);
    assign fifo_wr    = xfer;
    assign fifo_data  = reset ? '0 : req_data[owner*DATA_W +: DATA_W];

    always_comb begin
        gnt = '0;
        if (xfer) gnt[owner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= pick(req, rr_ptr);
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) burst_cnt <= burst_cnt + BW'(1);
                    // Handover is zero-bubble: the new winner is chosen in the exit cycle.
                    if (exit_grant) begin
                        rr_ptr <= next_ptr;
                        if (|req) begin
                            owner     <= pick(req, next_ptr);
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || stall_clr) begin
            stall_cnt <= '0;
        end else if ((state == GRANT) && req[owner] && fifo_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues feed req/req_data, a scoreboard
// holds the expected (owner, word) write order. Build with FIFO_ARB_STALL_CNT_EN for stall_cnt.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic [1:0]  owner;
    logic        busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic        stall_clr = 1'b0;
    logic [15:0] stall_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .owner     (owner),
        .busy      (busy)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  src_mem [4][80];
    int          src_head [4];
    int          src_tail [4];
    logic [11:0] exp_q [$];
    int          fifo_cnt = 0;
    logic        force_full = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = (src_head[i] != src_tail[i]);
            req_data[i*8 +: 8] = src_mem[i][src_head[i]];
        end
        fifo_full = (fifo_cnt >= 64) || force_full;
    endtask

    task automatic load(input int r, input int n, input logic [7:0] base);
        if (src_head[r] == src_tail[r]) begin
            src_head[r] = 0;
            src_tail[r] = 0;
        end
        for (int k = 0; k < n; k++) begin
            src_mem[r][src_tail[r]] = base + 8'(k);
            src_tail[r]++;
        end
        drive();
    endtask

    task automatic expect_w(input int o, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) exp_q.push_back({4'(o), base + 8'(k)});
    endtask

    // One clock: check at the falling edge, then apply accepts and new inputs after the rising edge.
    task automatic tick(input int ew, input int eb, input int eo);
        logic [3:0]  sg;
        logic        sw;
        logic [11:0] e;
        @(negedge clk);
        if (ew >= 0) chk("fifo_wr", 32'(fifo_wr), 32'(ew));
        if (eb >= 0) chk("busy", 32'(busy), 32'(eb));
        if (eo >= 0) chk("owner", 32'(owner), 32'(eo));
        if (fifo_full) chk("wr_while_full", 32'(fifo_wr), 32'd0);
        if (fifo_wr) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_write", 32'(fifo_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(fifo_data), 32'(e[7:0]));
                chk("sb_gnt", 32'(gnt), 32'(4'b0001 << e[9:8]));
            end
        end else begin
            chk("gnt_idle", 32'(gnt), 32'd0);
        end
        sg = gnt;
        sw = fifo_wr;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (sg[i]) src_head[i]++;
        if (sw) fifo_cnt++;
        #1 drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        drive();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick(0, -1, -1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
            for (int k = 0; k < 80; k++) src_mem[i][k] = '0;
        end
        drive();
        do_reset();

        // Single requester: bubble, burst of 4, zero-bubble re-win, 2 more words.
        load(0, 6, 8'h11);
        expect_w(0, 6, 8'h11);
        tick(0, 0, -1);
        for (int k = 0; k < 6; k++) tick(1, 1, 0);
        drain(2);

        // All four requesting: owners 0,1,2,3,0 with 4 words each, no idle cycles.
        do_reset();
        load(0, 8, 8'h80); load(1, 4, 8'h90); load(2, 4, 8'hA0); load(3, 4, 8'hB0);
        expect_w(0, 4, 8'h80); expect_w(1, 4, 8'h90); expect_w(2, 4, 8'hA0);
        expect_w(3, 4, 8'hB0); expect_w(0, 4, 8'h84);
        tick(0, 0, -1);
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++) tick(1, 1, b % 4);
        drain(3);

        // Back-pressure on owner 2 after 2 words for 5 cycles, then rotation to 3.
        load(2, 4, 8'hC0); load(3, 4, 8'hD0);
        expect_w(2, 4, 8'hC0); expect_w(3, 4, 8'hD0);
        tick(0, 0, -1);
        tick(1, 1, 2); tick(1, 1, 2);
        force_full = 1'b1; drive();
        for (int k = 0; k < 5; k++) tick(0, 1, 2);
        force_full = 1'b0; drive();
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
        stall_clr = 1'b1;
`endif
        tick(1, 1, 2);
`ifdef FIFO_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
        chk("stall_clr", 32'(stall_cnt), 32'd0);
`endif
        tick(1, 1, 2);
        for (int k = 0; k < 4; k++) tick(1, 1, 3);
        drain(3);

        // Withdraw: owner 1 drops req after one word; 3 takes over next cycle, 2 skipped.
        load(1, 4, 8'h40); load(3, 4, 8'h50);
        expect_w(1, 1, 8'h40); expect_w(3, 4, 8'h50);
        tick(0, 0, -1);
        tick(1, 1, 1);
        src_head[1] = src_tail[1]; drive();
        tick(0, 1, 1);
        for (int k = 0; k < 4; k++) tick(1, 1, 3);
        drain(3);

        // Reset in the 3rd word cycle of owner 3's burst; re-arbitration restarts at index 0.
        load(2, 4, 8'h60);
        expect_w(2, 4, 8'h60);
        tick(0, 0, -1);
        for (int k = 0; k < 4; k++) tick(1, 1, 2);
        drain(2);
        load(3, 6, 8'h70); load(1, 2, 8'h78);
        expect_w(3, 2, 8'h70); expect_w(1, 2, 8'h78); expect_w(3, 4, 8'h72);
        tick(0, 0, -1);
        tick(1, 1, 3); tick(1, 1, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_wr", 32'(fifo_wr), 32'd0);
        chk("midrst_data", 32'(fifo_data), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive();
        tick(0, 0, 0);
        tick(1, 1, 1); tick(1, 1, 1);
        tick(0, 1, 1);
        for (int k = 0; k < 4; k++) tick(1, 1, 3);
        drain(3);

        // FIFO fill: 64 writes, word 65 held while full, accepted once space appears.
        fifo_cnt = 0;
        load(0, 65, 8'h00);
        expect_w(0, 65, 8'h00);
        tick(0, 0, -1);
        for (int k = 0; k < 64; k++) tick(1, 1, 0);
        chk("full_after_64", 32'(fifo_full), 32'd1);
        for (int k = 0; k < 3; k++) tick(0, 1, 0);
        fifo_cnt = 0; drive();
        tick(1, 1, 0);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
